conv5x5_engine: RTL
===================

CONV5X5_ENGINE -- requirements
Module: conv5x5_engine

Interface
REQ-001 Parameter ADDR_W, default 24, sets the VRAM byte-address width.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-005 image_size  in  16  square source image side in pixels, which is also the row stride in bytes.
REQ-006 src_base  in  ADDR_W  byte address of source pixel (0,0).
REQ-007 dst_base  in  ADDR_W  byte address of output pixel (0,0).
REQ-008 kernel  in  200  25 signed 8-bit weights; byte t (bits 8t+7:8t) is tap t = row t/5, col t%5.
REQ-009 shift  in  4  arithmetic right-shift applied to the accumulated sum.
REQ-010 daddr  out  ADDR_W  window top-left address presented to the VRAM 5x5 read port.
REQ-011 drdata  in  200  combinational 5x5 window from VRAM; byte t = pixel at daddr + (t/5)*image_size + t%5, unsigned.
REQ-012 destination_addr_from_acc  out  ADDR_W  result write address.
REQ-013 dwdata_from_acc  out  8  result byte.
REQ-014 dwe_from_acc  out  1  result write strobe; one byte is written per high cycle.
REQ-015 busy  out  1  high from the cycle after an accepted start until the done pulse.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 Start latches image_size, src_base, dst_base, kernel and shift; the job uses only these latched copies, so input changes mid-job have no effect.
REQ-018 Output side N = image_size-4 (valid convolution, no padding); outputs are produced row-major for r = 0..N-1 and c = 0..N-1.
REQ-019 The FSM has states IDLE, FETCH, MAC, WRITE, FIN.
- IDLE -> FETCH on start when image_size >= 5.
- IDLE -> FIN on start when image_size < 5.
REQ-020 FETCH (1 cycle):
- daddr = src_base + r*image_size + c.
- drdata is registered into a window buffer at the end of the cycle.
- accumulator is cleared to 0.
- next state is MAC.
REQ-021 MAC (exactly 25 cycles, tap t = 0..24 in order): acc += window byte t (zero-extended) * kernel byte t (signed); the next state is WRITE.
REQ-022 The accumulator is 22-bit signed and cannot overflow (25 * 255 * 128 < 2^21).
REQ-023 WRITE (1 cycle) drives three registered outputs from the same cycle:
- dwe_from_acc = 1.
- destination_addr_from_acc = dst_base + r*N + c.
- dwdata_from_acc = clamp(acc >>> shift, 0, 255).
REQ-024 Clamp rule: negative results -> 0x00; results > 255 -> 0xFF.
REQ-025 Leaving WRITE:
- if c < N-1: c++ and go to FETCH.
- else if r < N-1: c = 0, r++ and go to FETCH.
- else go to FIN.
REQ-026 FIN (1 cycle): done = 1, busy = 0, next state IDLE.
REQ-027 Each output pixel costs 27 cycles; a job with N >= 1 takes 27*N*N + 1 cycles from the start edge to the done cycle.
REQ-028 dwe_from_acc is high only in WRITE; destination_addr_from_acc and dwdata_from_acc hold their last values otherwise.
REQ-029 start while not in IDLE is ignored; start in the FIN cycle is also ignored.
REQ-030 Address arithmetic is modulo 2^ADDR_W (wraps silently).
REQ-031 The block never asserts dwe_from_acc while reading the same window in FETCH.
- The window is buffered before any write.
- An in-place job (dst_base == src_base) is legal, with results defined by this sequential order.

Reset
REQ-032 On reset (any state, including mid-MAC or mid-WRITE) the next state is IDLE, and these are cleared:
- outputs daddr, destination_addr_from_acc, dwdata_from_acc, dwe_from_acc, busy, done = 0.
- internal state r, c, tap index, acc and window buffer = 0.
REQ-033 A reset cycle that coincides with WRITE suppresses that write (dwe_from_acc low in the following cycle).
REQ-034 After reset the block accepts start on the first cycle reset is low.

Verification
REQ-035 image_size=5, all pixels 1, kernel all 1, shift=0 -> one write of 25 (0x19) to dst_base; done 28 cycles after the start edge.
REQ-036 image_size=6, pixel(x,y)=x+y, kernel centre tap (t=12) = 1 and others 0, dst_base=0x1000:
- writes 4 in order: 0x1000=4, 0x1001=5, 0x1002=5, 0x1003=6.
- daddr values src_base+0, +1, +6, +7.
REQ-037 image_size=5, all pixels 255, kernel all -1 -> write 0x00; with kernel all 127 and shift=4 -> write 0xFF.
REQ-038 image_size=4 -> done asserted in the cycle after start, dwe_from_acc never asserted, busy never high.
REQ-039 Assert reset at MAC tap 10 of the second pixel, then release:
- no further writes occur.
- all outputs read 0.
- a fresh start reruns the whole job correctly.
REQ-040 Pulse start again at cycles 3 and 20 of a running job -> ignored; the write count and done timing are unchanged.

Source files
------------

// File: rtl/conv5x5_engine.sv
// 5x5 valid-convolution engine: fetches one VRAM window per output pixel, runs 25
// sequential MACs, then writes a clamped 8-bit result row-major to the destination.
module conv5x5_engine #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       image_size,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [199:0]      kernel,
    input  logic [3:0]        shift,
    output logic [ADDR_W-1:0] daddr,
    input  logic [199:0]      drdata,
    output logic [ADDR_W-1:0] destination_addr_from_acc,
    output logic [7:0]        dwdata_from_acc,
    output logic              dwe_from_acc,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);
    // start is a one-cycle request honoured only in IDLE (no ready); done is a one-cycle
    // pulse with no backpressure; dwe_from_acc writes exactly one byte per high cycle.
    typedef enum logic [2:0] {IDLE, FETCH, MAC, WRITE, FIN} state_t;

    state_t             state_q, state_d;
    logic [15:0]        size_q, size_d, n_q, n_d, r_q, r_d, c_q, c_d;
    logic [199:0]       kernel_q, kernel_d, win_q, win_d;
    logic [3:0]         shift_q, shift_d;
    logic [4:0]         tap_q, tap_d;
    logic signed [21:0] acc_q, acc_d;
    logic [ADDR_W-1:0]  src_row_q, src_row_d, dst_row_q, dst_row_d;
    logic [ADDR_W-1:0]  daddr_q, daddr_d, dest_q, dest_d;
    logic [7:0]         dwdata_q, dwdata_d;
    logic               dwe_q, dwe_d, busy_q, busy_d, done_q, done_d;

    logic [7:0]         pix, kbyte, clamp_val;
    logic signed [16:0] prod;
    logic signed [21:0] acc_sum, shifted;

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        n_d       = n_q;
        r_d       = r_q;
        c_d       = c_q;
        kernel_d  = kernel_q;
        win_d     = win_q;
        shift_d   = shift_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        src_row_d = src_row_q;
        dst_row_d = dst_row_q;
        daddr_d   = daddr_q;
        dest_d    = dest_q;
        dwdata_d  = dwdata_q;
        dwe_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Pixel is unsigned, weight is signed: the zero-extended pixel keeps the product exact.
        pix       = win_q[{tap_q, 3'b000} +: 8];
        kbyte     = kernel_q[{tap_q, 3'b000} +: 8];
        prod      = $signed({1'b0, pix}) * $signed(kbyte);
        acc_sum   = acc_q + $signed({{5{prod[16]}}, prod});
        shifted   = acc_sum >>> shift_q;
        if (shifted[21])
            clamp_val = 8'h00;
        else if (|shifted[20:8])
            clamp_val = 8'hFF;
        else
            clamp_val = shifted[7:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    size_d    = image_size;
                    kernel_d  = kernel;
                    shift_d   = shift;
                    r_d       = '0;
                    c_d       = '0;
                    src_row_d = src_base;
                    dst_row_d = dst_base;
                    if (image_size >= 16'd5) begin
                        n_d     = image_size - 16'd4;
                        daddr_d = src_base;
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        n_d     = '0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            FETCH: begin
                win_d   = drdata;
                acc_d   = '0;
                tap_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_sum;
                if (tap_q == 5'd24) begin
                    dwe_d    = 1'b1;
                    dest_d   = dst_row_q + ADDR_W'(c_q);
                    dwdata_d = clamp_val;
                    state_d  = WRITE;
                end else begin
                    tap_d = tap_q + 5'd1;
                end
            end
            WRITE: begin
                if (c_q < n_q - 16'd1) begin
                    c_d     = c_q + 16'd1;
                    daddr_d = src_row_q + ADDR_W'(c_q + 16'd1);
                    state_d = FETCH;
                end else if (r_q < n_q - 16'd1) begin
                    r_d       = r_q + 16'd1;
                    c_d       = '0;
                    src_row_d = src_row_q + ADDR_W'(size_q);
                    dst_row_d = dst_row_q + ADDR_W'(n_q);
                    daddr_d   = src_row_q + ADDR_W'(size_q);
                    state_d   = FETCH;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            size_q    <= '0;
            n_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            kernel_q  <= '0;
            win_q     <= '0;
            shift_q   <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            src_row_q <= '0;
            dst_row_q <= '0;
            daddr_q   <= '0;
            dest_q    <= '0;
            dwdata_q  <= '0;
            dwe_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            n_q       <= n_d;
            r_q       <= r_d;
            c_q       <= c_d;
            kernel_q  <= kernel_d;
            win_q     <= win_d;
            shift_q   <= shift_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            src_row_q <= src_row_d;
            dst_row_q <= dst_row_d;
            daddr_q   <= daddr_d;
            dest_q    <= dest_d;
            dwdata_q  <= dwdata_d;
            dwe_q     <= dwe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign daddr                     = daddr_q;
    assign destination_addr_from_acc = dest_q;
    assign dwdata_from_acc           = dwdata_q;
    assign dwe_from_acc              = dwe_q;
    assign busy                      = busy_q;
    assign done                      = done_q;
    assign dbg_state                 = state_q;
endmodule
